// File: rtl/writeback_regfile.sv
// Y86-64 SEQ write-back stage: destination decode, 15 x 64-bit register
// file with two combinational read ports, sticky status and retire counter.
module writeback_regfile #(
    parameter logic [63:0] RSP_INIT = 64'h0000_0000_0000_0F00,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_valid,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [63:0]      valE,
    input  logic [63:0]      valM,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             dmem_error,
    input  logic [3:0]       srcA,
    input  logic [3:0]       srcB,
    output logic [63:0]      valA_rd,
    output logic [63:0]      valB_rd,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] REG_RSP = 4'h4;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    logic [63:0]      rf_r [0:14];
    logic [2:0]       stat_r;
    logic             halted_r;
    logic [CNT_W-1:0] retired_r;

    logic [3:0] dst_e_s;
    logic [3:0] dst_m_s;
    logic [2:0] cyc_stat_s;
    logic       commit_s;
    logic       fault_s;

    // Destination decode: which registers this instruction would write.
    always_comb begin
        dst_e_s = RNONE;
        dst_m_s = RNONE;
        case (icode)
            IRRMOVQ: begin
                if (cnd) begin
                    dst_e_s = rB;
                end else begin
                    dst_e_s = RNONE;
                end
            end
            IIRMOVQ, IOPQ:               dst_e_s = rB;
            IPUSHQ, ICALL, IRET:         dst_e_s = REG_RSP;
            IPOPQ: begin
                dst_e_s = REG_RSP;
                dst_m_s = rA;
            end
            IMRMOVQ:                     dst_m_s = rA;
            default: begin
                dst_e_s = RNONE;
                dst_m_s = RNONE;
            end
        endcase
    end

    // Per-cycle status with fetch faults taking priority over memory faults.
    always_comb begin
        cyc_stat_s = STAT_AOK;
        if (imem_error) begin
            cyc_stat_s = STAT_ADR;
        end else if (!instr_valid) begin
            cyc_stat_s = STAT_INS;
        end else if (dmem_error) begin
            cyc_stat_s = STAT_ADR;
        end else if (icode == IHALT) begin
            cyc_stat_s = STAT_HLT;
        end else begin
            cyc_stat_s = STAT_AOK;
        end
    end

    // Commit only a valid, clean instruction while the machine is still running.
    always_comb begin
        commit_s = wb_valid && !halted_r && (cyc_stat_s == STAT_AOK);
        fault_s  = wb_valid && !halted_r && (cyc_stat_s != STAT_AOK);
    end

    // Register file update; the M write is issued last so popq %rsp keeps valM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                rf_r[i] <= (i == 4) ? RSP_INIT : 64'h0;
            end
        end else if (commit_s) begin
            if (dst_e_s != RNONE) begin
                rf_r[dst_e_s] <= valE;
            end
            if (dst_m_s != RNONE) begin
                rf_r[dst_m_s] <= valM;
            end
        end
    end

    // Sticky status and retire counter; HLT retires, address/instr faults do not.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_r    <= STAT_AOK;
            halted_r  <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (fault_s) begin
            stat_r   <= cyc_stat_s;
            halted_r <= 1'b1;
            if (cyc_stat_s == STAT_HLT) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Decode read ports: stored state only, RNONE reads as zero.
    always_comb begin
        if (srcA == RNONE) begin
            valA_rd = 64'h0;
        end else begin
            valA_rd = rf_r[srcA];
        end
        if (srcB == RNONE) begin
            valB_rd = 64'h0;
        end else begin
            valB_rd = rf_r[srcB];
        end
    end

    assign stat    = stat_r;
    assign halted  = halted_r;
    assign retired = retired_r;

endmodule
